// File: rtl/tl_a_repeater.sv
// Single-entry TileLink-UL A-channel repeater: passes requests straight through, or holds one
// beat and replays it for as long as the downstream consumer keeps asserting repeat.
module tl_a_repeater #(
  parameter int ADDR_W = 15,
  parameter int SRC_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  // "repeat" is a reserved word in SystemVerilog, so the replay request carries a suffix.
  input  logic                repeat_i,
  input  logic                enq_valid,
  output logic                enq_ready,
  input  logic [2:0]          enq_opcode,
  input  logic [2:0]          enq_param,
  input  logic [2:0]          enq_size,
  input  logic [SRC_W-1:0]    enq_source,
  input  logic [ADDR_W-1:0]   enq_address,
  input  logic [DATA_W/8-1:0] enq_mask,
  input  logic [DATA_W-1:0]   enq_data,
  input  logic                enq_corrupt,
  output logic                deq_valid,
  input  logic                deq_ready,
  output logic [2:0]          deq_opcode,
  output logic [2:0]          deq_param,
  output logic [2:0]          deq_size,
  output logic [SRC_W-1:0]    deq_source,
  output logic [ADDR_W-1:0]   deq_address,
  output logic [DATA_W/8-1:0] deq_mask,
  output logic [DATA_W-1:0]   deq_data,
  output logic                deq_corrupt,
  output logic                full,
  output logic [DATA_W/8-1:0] saved_mask,
  output logic                repeat_err
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          s_opcode_q, s_param_q, s_size_q;
  logic [SRC_W-1:0]    s_source_q;
  logic [ADDR_W-1:0]   s_address_q;
  logic [MASK_W-1:0]   s_mask_q;
  logic [DATA_W-1:0]   s_data_q;
  logic                s_corrupt_q;
  logic                repeat_err_q, repeat_err_d;

  logic held;
  logic enq_fire;
  logic deq_fire;
  logic capture;

  // Fire terms are built from state directly so no path runs through the output process.
  assign held     = (state_q == HELD);
  assign enq_fire = enq_valid & deq_ready & ~held;
  assign deq_fire = (enq_valid | held) & deq_ready;
  assign capture  = enq_fire & repeat_i;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= EMPTY;
      repeat_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      repeat_err_q <= repeat_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (capture) state_d = HELD;
      HELD:    if (deq_fire && !repeat_i) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // A repeat is only legal on a full-mask beat; flag partial captures for one cycle.
  assign repeat_err_d = capture & (enq_mask != {MASK_W{1'b1}});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_opcode_q  <= '0;
      s_param_q   <= '0;
      s_size_q    <= '0;
      s_source_q  <= '0;
      s_address_q <= '0;
      s_mask_q    <= '0;
      s_data_q    <= '0;
      s_corrupt_q <= 1'b0;
    end else if (capture) begin
      s_opcode_q  <= enq_opcode;
      s_param_q   <= enq_param;
      s_size_q    <= enq_size;
      s_source_q  <= enq_source;
      s_address_q <= enq_address;
      s_mask_q    <= enq_mask;
      s_data_q    <= enq_data;
      s_corrupt_q <= enq_corrupt;
    end
  end

  always_comb begin
    full        = held;
    deq_valid   = enq_valid | held;
    enq_ready   = deq_ready & ~held;
    deq_opcode  = held ? s_opcode_q  : enq_opcode;
    deq_param   = held ? s_param_q   : enq_param;
    deq_size    = held ? s_size_q    : enq_size;
    deq_source  = held ? s_source_q  : enq_source;
    deq_address = held ? s_address_q : enq_address;
    deq_mask    = held ? s_mask_q    : enq_mask;
    deq_data    = held ? s_data_q    : enq_data;
    deq_corrupt = held ? s_corrupt_q : enq_corrupt;
    saved_mask  = held ? s_mask_q    : '0;
    repeat_err  = repeat_err_q;
  end

endmodule

// File: tb/tb_tl_a_repeater.sv
// Self-checking bench for tl_a_repeater: directed scenarios followed by random traffic,
// all compared against a queue-based model of the held beat.
module tb_tl_a_repeater;

  localparam int ADDR_W = 15;
  localparam int SRC_W  = 5;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [2:0]        param;
    logic [2:0]        size;
    logic [SRC_W-1:0]  source;
    logic [ADDR_W-1:0] address;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
    logic              corrupt;
  } beat_t;

  logic clock = 1'b0;
  logic reset_n;
  logic rpt;
  logic enq_valid;
  logic deq_ready;
  beat_t in_b;

  logic              enq_ready, deq_valid, full, repeat_err, deq_corrupt;
  logic [2:0]        deq_opcode, deq_param, deq_size;
  logic [SRC_W-1:0]  deq_source;
  logic [ADDR_W-1:0] deq_address;
  logic [MASK_W-1:0] deq_mask, saved_mask;
  logic [DATA_W-1:0] deq_data;

  int vectors = 0;
  int miscompares = 0;

  beat_t held_q[$];
  logic  err_m = 1'b0;

  always #5 clock = ~clock;

  tl_a_repeater #(.ADDR_W(ADDR_W), .SRC_W(SRC_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n), .repeat_i(rpt),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_opcode(in_b.opcode), .enq_param(in_b.param), .enq_size(in_b.size),
    .enq_source(in_b.source), .enq_address(in_b.address), .enq_mask(in_b.mask),
    .enq_data(in_b.data), .enq_corrupt(in_b.corrupt),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_opcode(deq_opcode), .deq_param(deq_param), .deq_size(deq_size),
    .deq_source(deq_source), .deq_address(deq_address), .deq_mask(deq_mask),
    .deq_data(deq_data), .deq_corrupt(deq_corrupt),
    .full(full), .saved_mask(saved_mask), .repeat_err(repeat_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are combinational from inputs and the held beat; compare after inputs settle.
  task automatic settle_check(input string tag);
    beat_t exp_b;
    beat_t obs_b;
    logic  h;
    #1;
    h     = (held_q.size() != 0);
    exp_b = h ? held_q[0] : in_b;
    obs_b = {deq_opcode, deq_param, deq_size, deq_source, deq_address, deq_mask,
             deq_data, deq_corrupt};
    chk({tag, ".deq_valid"}, 128'(deq_valid), 128'(enq_valid | h));
    chk({tag, ".enq_ready"}, 128'(enq_ready), 128'(deq_ready & ~h));
    chk({tag, ".deq_beat"}, 128'(obs_b), 128'(exp_b));
    chk({tag, ".full"}, 128'(full), 128'(h));
    chk({tag, ".saved_mask"}, 128'(saved_mask), 128'(h ? held_q[0].mask : '0));
    chk({tag, ".repeat_err"}, 128'(repeat_err), 128'(err_m));
  endtask

  // Advance one clock: a beat is held after a repeated transfer and released by a plain one.
  task automatic tick();
    logic h;
    logic nerr;
    h    = (held_q.size() != 0);
    nerr = 1'b0;
    if (h) begin
      if (deq_ready && !rpt) void'(held_q.pop_front());
    end else if (enq_valid && deq_ready && rpt) begin
      held_q.push_back(in_b);
      nerr = (in_b.mask != {MASK_W{1'b1}});
    end
    @(posedge clock);
    err_m = nerr;
    @(negedge clock);
  endtask

  task automatic rand_beat();
    in_b.opcode  = 3'($urandom);
    in_b.param   = 3'($urandom);
    in_b.size    = 3'($urandom);
    in_b.source  = SRC_W'($urandom);
    in_b.address = ADDR_W'($urandom);
    in_b.mask    = ($urandom_range(0, 1) != 0) ? {MASK_W{1'b1}} : MASK_W'($urandom);
    in_b.data    = DATA_W'($urandom);
    in_b.corrupt = 1'($urandom);
  endtask

  initial begin
    reset_n   = 1'b0;
    rpt       = 1'b0;
    enq_valid = 1'b1;
    deq_ready = 1'b1;
    rand_beat();
    repeat (2) @(negedge clock);
    settle_check("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // Pass-through
    in_b.address = 15'h1234;
    in_b.source  = 5'd5;
    settle_check("pass");
    chk("pass.addr", 128'(deq_address), 128'h1234);
    chk("pass.src", 128'(deq_source), 128'd5);
    tick();
    settle_check("pass2");

    // Single repeat
    in_b.opcode  = 3'd4;
    in_b.address = 15'h0040;
    in_b.mask    = 4'hF;
    rpt          = 1'b1;
    settle_check("single.cap");
    tick();
    rpt          = 1'b0;
    in_b.address = 15'h0080;
    settle_check("single.held");
    chk("single.full", 128'(full), 128'd1);
    chk("single.enq_ready", 128'(enq_ready), 128'd0);
    chk("single.addr", 128'(deq_address), 128'h0040);
    tick();
    settle_check("single.rel");
    chk("single.full0", 128'(full), 128'd0);
    chk("single.pass", 128'(deq_address), 128'h0080);
    tick();

    // Multi-repeat: three repeated transfers then a final plain one
    in_b.address = 15'h0100;
    in_b.mask    = 4'hF;
    rpt          = 1'b1;
    settle_check("multi.cap");
    tick();
    in_b.address = 15'h0200;
    for (int i = 0; i < 3; i++) begin
      rpt = (i < 2);
      settle_check("multi.held");
      chk("multi.smask", 128'(saved_mask), 128'hF);
      chk("multi.addr", 128'(deq_address), 128'h0100);
      tick();
    end
    settle_check("multi.rel");
    chk("multi.full0", 128'(full), 128'd0);
    tick();

    // Backpressure while held
    in_b.address = 15'h0300;
    rpt          = 1'b1;
    settle_check("bp.cap");
    tick();
    rpt          = 1'b0;
    deq_ready    = 1'b0;
    in_b.address = 15'h03FC;
    for (int i = 0; i < 5; i++) begin
      settle_check("bp.stall");
      chk("bp.valid", 128'(deq_valid), 128'd1);
      chk("bp.enq_ready", 128'(enq_ready), 128'd0);
      chk("bp.full", 128'(full), 128'd1);
      chk("bp.addr", 128'(deq_address), 128'h0300);
      tick();
    end
    deq_ready = 1'b1;
    settle_check("bp.rel");
    tick();
    settle_check("bp.after");
    chk("bp.full0", 128'(full), 128'd0);

    // Partial-mask repeat, then reset while held
    in_b.address = 15'h0500;
    in_b.mask    = 4'h3;
    rpt          = 1'b1;
    settle_check("part.cap");
    tick();
    rpt       = 1'b0;
    deq_ready = 1'b0;
    settle_check("part.held");
    chk("part.err", 128'(repeat_err), 128'd1);
    chk("part.smask", 128'(saved_mask), 128'h3);
    tick();
    settle_check("part.held2");
    chk("part.err_pulse", 128'(repeat_err), 128'd0);
    chk("part.full", 128'(full), 128'd1);
    reset_n = 1'b0;
    #1;
    chk("rst.full", 128'(full), 128'd0);
    chk("rst.smask", 128'(saved_mask), 128'd0);
    chk("rst.err", 128'(repeat_err), 128'd0);
    held_q.delete();
    err_m = 1'b0;
    @(negedge clock);
    reset_n      = 1'b1;
    deq_ready    = 1'b1;
    in_b.address = 15'h0777;
    settle_check("rst.pass");
    chk("rst.pass_addr", 128'(deq_address), 128'h0777);
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_beat();
      enq_valid = ($urandom_range(0, 3) != 0);
      deq_ready = ($urandom_range(0, 3) != 0);
      rpt       = ($urandom_range(0, 2) == 0);
      settle_check("rand");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tl_a_repeater.md
# tl_a_repeater

Single-entry TileLink-UL A-channel repeater placed directly upstream of the A-channel protocol monitor. It either passes a request straight through combinationally or captures it, when the downstream consumer asserts `repeat`, and re-presents the identical request on following cycles until it is accepted without `repeat`. It exports its `full` state and the captured mask so the monitor can check that a repeat is only held with a full byte mask.

## Interface
Parameters:
- `ADDR_W`, 15, address width
- `SRC_W`, 5, source ID width
- `DATA_W`, 32, data width; mask width is `DATA_W/8`

Ports:
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `repeat`  in  1  downstream request to keep the current beat for replay
- `enq_valid`  in  1  upstream request valid
- `enq_ready`  out  1  repeater can accept a request
- `enq_opcode`, `enq_param`, `enq_size`  in  3 each  A-channel fields
- `enq_source`  in  SRC_W  request source ID
- `enq_address`  in  ADDR_W  request address
- `enq_mask`  in  DATA_W/8  byte mask
- `enq_data`  in  DATA_W  write data
- `enq_corrupt`  in  1  corrupt flag
- `deq_valid`  out  1  request presented downstream
- `deq_ready`  in  1  downstream accepts
- `deq_opcode` … `deq_corrupt`  out  same widths as the `enq_*` fields  presented request
- `full`  out  1  a saved request is held
- `saved_mask`  out  DATA_W/8  mask of the held request; all zeros when empty
- `repeat_err`  out  1  registered one-cycle pulse: a repeat was captured with a partial mask

## Operation
- State is the `full` bit plus the saved field registers (`s_opcode` … `s_corrupt`). States: EMPTY (`full=0`) and HELD (`full=1`).
- Outputs, combinational:
  - `deq_valid = enq_valid | full`
  - `enq_ready = deq_ready & ~full`
  - each `deq_*` field is `full ? s_* : enq_*`
- Fire terms: `enq_fire = enq_valid & enq_ready`; `deq_fire = deq_valid & deq_ready`.
- EMPTY→HELD: on `enq_fire & repeat`, capture all `enq_*` fields into `s_*` and set `full`.
- HELD→EMPTY: on `deq_fire & ~repeat`, clear `full`. The saved fields keep their values.
- HELD with `deq_fire & repeat`: stay HELD and leave the saved fields unchanged. The same beat is replayed.
- HELD with `enq_valid`: `enq_ready=0`. No capture; upstream stalls.
- EMPTY with `repeat` but no `enq_fire`: no state change.
- `saved_mask = full ? s_mask : 0`.
- `repeat_err` is set for one cycle after an `enq_fire & repeat` whose `enq_mask` is not all ones. It is not sticky.
- Simultaneous events:
  - In HELD, `enq_fire` is impossible, so a capture and a release can never coincide.
  - In EMPTY, `enq_fire & ~repeat` is a pure pass-through with no state change.
- Reset: `full=0`, saved fields `=0`, `repeat_err=0`.
  - A reset in HELD drops the held request with no replay.
  - After reset, `deq_valid` follows `enq_valid` combinationally.

## Timing
- Pass-through latency is 0 cycles (combinational `enq_*`→`deq_*` when EMPTY).
- Capture takes effect at the rising edge where `enq_fire & repeat`. `full=1` and the saved beat are visible from the next cycle.
- Release takes effect at the edge where `deq_fire & ~repeat`. `enq_ready` can rise in the following cycle.
- Throughput:
  - 1 beat/cycle when no repeat is requested.
  - A repeated beat occupies N+1 `deq` transfers for N consecutive cycles of `repeat`.
- `repeat_err` is valid in the cycle after the offending capture.
- `reset_n` asserts asynchronously. Deassertion is synchronised externally.
- Reset values of outputs:
  - `full=0`, `saved_mask=0`, `repeat_err=0`
  - `enq_ready = deq_ready`
  - `deq_valid = enq_valid`
  - `deq_*` equal to `enq_*`

## Test plan
- **Pass-through:** `enq_valid=1`, `deq_ready=1`, `repeat=0`, address 0x1234, source 5 → `deq` shows 0x1234 and source 5 in the same cycle; `full` stays 0.
- **Single repeat:** Get, address 0x0040, mask 0xF, with `repeat=1` for one fire then 0.
  - Next cycle: `full=1`, `enq_ready=0`, `deq_address=0x0040` although `enq_address` has changed to 0x0080.
  - After the second `deq_fire` with `repeat=0`: `full=0`, and 0x0080 passes.
- **Multi-repeat:** hold `repeat=1` for 3 `deq_fire`s → identical beat on 4 transfers; `saved_mask=0xF` throughout; `full` clears after the 4th.
- **Backpressure while HELD:** `deq_ready=0` for 5 cycles → `deq_valid=1` with stable fields, `enq_ready=0`, `full` stays 1.
- **Partial-mask repeat:** capture with `enq_mask=0x3`, `repeat=1` → `repeat_err=1` for exactly one cycle; `saved_mask=0x3`.
- **Reset mid-HELD:** assert `reset_n=0` while `full=1` → `full`, `saved_mask` and `repeat_err` go to 0 immediately (asynchronously); after release, the next `enq` passes through unchanged.
